// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM duty sequencer.
// PWM_SEQ_READBACK_EN adds the read-back states to the state enum.
package pwm_seq_pkg;

  localparam logic [1:0]  AXI_RESP_OKAY       = 2'b00;
  localparam logic [31:0] PWM_BASE_DEFAULT    = 32'h0000_0000;
  localparam logic [31:0] DUTY_OFFSET_DEFAULT = 32'h0000_0004;

`ifdef PWM_SEQ_READBACK_EN
  typedef enum logic [2:0] {
    StIdle,
    StWrAddrData,
    StWrResp,
    StRdAddr,
    StRdData
  } seq_state_e;
`else
  typedef enum logic [1:0] {
    StIdle,
    StWrAddrData,
    StWrResp
  } seq_state_e;
`endif

endpackage

// File: rtl/pwm_seq_table.sv
// Duty value table: DEPTH x DW storage, one synchronous write port and a
// combinational read port (a same-cycle write is seen by the reader next cycle).
module pwm_seq_table #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 32,
  localparam int unsigned IW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pwm_duty_sequencer.sv
// AXI4-Lite master that writes one table entry to the PWM duty register per trigger.
// Define PWM_SEQ_READBACK_EN to read the register back after each write and verify it.
module pwm_duty_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter logic [31:0] PWM_BASE    = PWM_BASE_DEFAULT,
  parameter logic [31:0] DUTY_OFFSET = DUTY_OFFSET_DEFAULT,
  localparam int unsigned IW         = $clog2(DEPTH),
  localparam int unsigned LW         = IW + 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  clr,
  input  logic [LW-1:0]         tbl_len,
  input  logic                  tbl_we,
  input  logic [IW-1:0]         tbl_addr,
  input  logic [31:0]           tbl_wdata,
  input  logic                  pwm_irq,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  output logic                  busy,
  output logic [IW-1:0]         cur_idx,
  output logic                  err,
  output logic                  overrun
);

  localparam logic [ADDR_WIDTH-1:0] DutyAddr = ADDR_WIDTH'(PWM_BASE + DUTY_OFFSET);

  seq_state_e            state_q;
  logic                  irq_q;
  logic                  pending_q;
  logic                  restart_q;
  logic                  err_q;
  logic                  overrun_q;
  logic [IW-1:0]         next_idx_q;
  logic [IW-1:0]         cur_idx_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;

  logic                  trig;
  logic                  start_trig;
  logic                  launch;
  logic                  b_done;
  logic                  err_set;
  logic                  in_write;
  logic [IW-1:0]         rd_idx;
  logic [IW-1:0]         wrap_idx;
  logic [LW-1:0]         len_eff;
  logic [31:0]           tbl_rdata;

  pwm_seq_table #(
    .DEPTH (DEPTH),
    .DW    (32)
  ) u_table (
    .clk_i   (ACLK),
    .we_i    (tbl_we),
    .waddr_i (tbl_addr),
    .wdata_i (tbl_wdata),
    .raddr_i (rd_idx),
    .rdata_o (tbl_rdata)
  );

  assign start_trig = enable & start;
  assign trig       = enable & (start | (pwm_irq & ~irq_q));
  assign launch     = (state_q == StIdle) & (trig | (pending_q & enable));
  assign rd_idx     = start_trig ? '0 : next_idx_q;
  assign b_done     = (state_q == StWrResp) & M_AXI_BVALID & bready_q;
  assign len_eff    = (tbl_len == '0) ? LW'(1) : tbl_len;
  assign wrap_idx   = ((LW'(cur_idx_q) + LW'(1)) >= len_eff) ? '0 : cur_idx_q + IW'(1);
  // A start seen before this write's response must survive the completion update.
  assign in_write   = (state_q == StWrAddrData) | ((state_q == StWrResp) & ~b_done);

`ifdef PWM_SEQ_READBACK_EN
  logic                  arvalid_q;
  logic                  rready_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic                  rd_done;

  assign rd_done = (state_q == StRdData) & M_AXI_RVALID & rready_q;
  assign err_set = (b_done & (M_AXI_BRESP != AXI_RESP_OKAY)) |
                   (rd_done & ((M_AXI_RRESP != AXI_RESP_OKAY) | (M_AXI_RDATA != wdata_q)));

  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
`else
  logic unused_rd;

  assign unused_rd = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
  assign err_set   = b_done & (M_AXI_BRESP != AXI_RESP_OKAY);

  assign M_AXI_ARADDR  = '0;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= StIdle;
      irq_q      <= 1'b0;
      pending_q  <= 1'b0;
      restart_q  <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
      next_idx_q <= '0;
      cur_idx_q  <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
`ifdef PWM_SEQ_READBACK_EN
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= '0;
`endif
    end else begin
      irq_q <= pwm_irq;

      unique case (state_q)
        StIdle: begin
          if (launch) begin
            state_q   <= StWrAddrData;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= DutyAddr;
            wdata_q   <= tbl_rdata;
            cur_idx_q <= rd_idx;
          end
        end
        StWrAddrData: begin
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
            state_q  <= StWrResp;
            bready_q <= 1'b1;
          end
        end
        StWrResp: begin
          if (b_done) begin
            bready_q <= 1'b0;
`ifdef PWM_SEQ_READBACK_EN
            state_q   <= StRdAddr;
            arvalid_q <= 1'b1;
            araddr_q  <= awaddr_q;
`else
            state_q   <= StIdle;
`endif
          end
        end
`ifdef PWM_SEQ_READBACK_EN
        StRdAddr: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdData;
          end
        end
        StRdData: begin
          if (rd_done) begin
            rready_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase

      // Pending holds at most one deferred trigger; a further one is lost.
      if (!enable || launch) begin
        pending_q <= 1'b0;
      end else if (trig && (state_q != StIdle)) begin
        pending_q <= 1'b1;
      end

      if (trig && pending_q) begin
        overrun_q <= 1'b1;
      end else if (clr) begin
        overrun_q <= 1'b0;
      end

      if (err_set) begin
        err_q <= 1'b1;
      end else if (clr) begin
        err_q <= 1'b0;
      end

      if (start_trig) begin
        next_idx_q <= '0;
      end else if (b_done) begin
        next_idx_q <= restart_q ? '0 : wrap_idx;
      end

      if (b_done) begin
        restart_q <= 1'b0;
      end else if (start_trig && in_write) begin
        restart_q <= 1'b1;
      end
    end
  end

  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;

  assign busy    = (state_q != StIdle);
  assign cur_idx = cur_idx_q;
  assign err     = err_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer with an AXI4-Lite slave model.
// Honours PWM_SEQ_READBACK_EN the same way as the design.
module tb_pwm_duty_sequencer;

  localparam int DEPTH = 16;
  localparam int IW    = 4;
  localparam int LW    = 5;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          enable, start, clr, tbl_we, pwm_irq;
  logic [LW-1:0] tbl_len;
  logic [IW-1:0] tbl_addr;
  logic [31:0]   tbl_wdata;
  logic [31:0]   AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]    AWPROT, ARPROT;
  logic [3:0]    WSTRB;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]    BRESP, RRESP;
  logic          busy, err, overrun;
  logic [IW-1:0] cur_idx;

  always #5 ACLK = ~ACLK;

  pwm_duty_sequencer #(.DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .start(start), .clr(clr),
    .tbl_len(tbl_len), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .pwm_irq(pwm_irq),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
    .M_AXI_AWREADY(AWREADY), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP),
    .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR),
    .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
    .M_AXI_RREADY(RREADY), .busy(busy), .cur_idx(cur_idx), .err(err), .overrun(overrun)
  );

  // ---------------- AXI4-Lite slave model ----------------
  int          aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] rd_xor = 32'h0;
  int          aw_cnt, w_cnt, b_cnt;
  logic        got_aw, got_w, b_arm;
  logic [31:0] s_addr, s_data, last_wdata;
  logic        aw_pend_prev, w_pend_prev;
  logic [31:0] prev_awaddr, prev_wdata;
  int          b_count = 0;
  int          stab_err = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic        aw_hs, w_hs;

  assign AWREADY = (aw_cnt >= aw_wait);
  assign WREADY  = (w_cnt >= w_wait);
  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; b_arm <= 1'b0;
      BVALID <= 1'b0; BRESP <= 2'b00;
      aw_pend_prev <= 1'b0; w_pend_prev <= 1'b0;
      s_addr <= '0; s_data <= '0; last_wdata <= '0;
    end else begin
      aw_pend_prev <= AWVALID & ~aw_hs;
      prev_awaddr  <= AWADDR;
      w_pend_prev  <= WVALID & ~w_hs;
      prev_wdata   <= WDATA;
      // A VALID must stay up, with stable payload, until its handshake.
      if (aw_pend_prev && (!AWVALID || AWADDR !== prev_awaddr)) stab_err <= stab_err + 1;
      if (w_pend_prev && (!WVALID || WDATA !== prev_wdata || WSTRB !== 4'hF))
        stab_err <= stab_err + 1;
      if (aw_hs) begin
        aw_cnt <= 0; got_aw <= 1'b1; s_addr <= AWADDR;
      end else if (AWVALID) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin
        w_cnt <= 0; got_w <= 1'b1; s_data <= WDATA;
      end else if (WVALID) w_cnt <= w_cnt + 1;
      if ((aw_hs && (got_w || w_hs)) || (w_hs && got_aw)) begin
        if (b_wait == 0) begin
          BVALID <= 1'b1; BRESP <= bresp_cfg;
        end else begin
          b_arm <= 1'b1; b_cnt <= 1;
        end
      end
      if (b_arm) begin
        if (b_cnt >= b_wait) begin
          BVALID <= 1'b1; BRESP <= bresp_cfg; b_arm <= 1'b0;
        end else b_cnt <= b_cnt + 1;
      end
      if (BVALID && BREADY) begin
        BVALID <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
        wq_addr.push_back(s_addr);
        wq_data.push_back(s_data);
        last_wdata <= s_data;
        b_count <= b_count + 1;
      end
    end
  end

`ifdef PWM_SEQ_READBACK_EN
  int rd_addr_err = 0;
  assign ARREADY = 1'b1;
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'b00;
    end else if (ARVALID && ARREADY) begin
      RVALID <= 1'b1; RDATA <= last_wdata ^ rd_xor; RRESP <= 2'b00;
      if (ARADDR !== 32'h4) rd_addr_err <= rd_addr_err + 1;
    end else if (RVALID && RREADY) begin
      RVALID <= 1'b0;
    end
  end
`else
  assign ARREADY = 1'b0;
  assign RVALID  = 1'b0;
  assign RDATA   = 32'h0;
  assign RRESP   = 2'b00;
`endif

  // ---------------- reference model and checking ----------------
  int          checks = 0, failures = 0;
  logic [31:0] mtbl [DEPTH];
  int          midx = 0, mlen = 1, nb = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tbl_write(input int a, input logic [31:0] d);
    tbl_we = 1'b1; tbl_addr = IW'(a); tbl_wdata = d;
    @(negedge ACLK);
    tbl_we = 1'b0;
    mtbl[a] = d;
  endtask

  task automatic set_len(input int n);
    tbl_len = LW'(n);
    mlen = (n == 0) ? 1 : n;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge ACLK); start = 1'b0;
    midx = 0;
  endtask

  task automatic pulse_irq();
    pwm_irq = 1'b1; @(negedge ACLK); pwm_irq = 1'b0; @(negedge ACLK);
  endtask

  task automatic pulse_clr();
    clr = 1'b1; @(negedge ACLK); clr = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(b_count >= nb && !busy) && n < 500) begin
      @(negedge ACLK); n++;
    end
    chk(tag, n < 500, 1);
  endtask

  // Pop one completed write and compare with the next model entry.
  task automatic expect_write(input string tag, input bit chk_idx);
    logic [31:0] a, d;
    if (wq_data.size() == 0) begin
      chk(tag, 0, 1);
    end else begin
      a = wq_addr.pop_front();
      d = wq_data.pop_front();
      chk(tag, d, mtbl[midx]);
      chk(tag, a, 32'h4);
      if (chk_idx) chk(tag, cur_idx, midx);
    end
    midx = (midx + 1) % mlen;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    enable = 1'b0; start = 1'b0; clr = 1'b0; tbl_we = 1'b0; pwm_irq = 1'b0;
    tbl_len = '0; tbl_addr = '0; tbl_wdata = '0;
    repeat (3) @(negedge ACLK);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_idx", cur_idx, 0);
    chk("rst_flags", {err, overrun}, 0);
    chk("rst_addr_data", {AWADDR, WDATA}, 0);
    chk("rst_rd", {ARVALID, RREADY}, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Basic playback with wrap
    tbl_write(0, 10); tbl_write(1, 20); tbl_write(2, 30);
    set_len(3); enable = 1'b1;
    @(negedge ACLK);
    pulse_start();
    n = 0;
    while (busy && n < 50) begin
      @(negedge ACLK); n++;
    end
`ifdef PWM_SEQ_READBACK_EN
    chk("min_period", n, 4);
`else
    chk("min_period", n, 2);
`endif
    nb++; wait_done("seq0_done"); expect_write("seq0", 1);
    for (int k = 0; k < 3; k++) begin
      pulse_irq(); nb++; wait_done("seq_done"); expect_write("seq", 1);
    end

    // Triggers ignored while disabled
    enable = 1'b0;
    pulse_irq(); repeat (3) @(negedge ACLK);
    chk("dis_busy", busy, 0);
    chk("dis_count", b_count, nb);
    enable = 1'b1;

    // AWREADY stalled, WREADY immediate
    aw_wait = 4;
    pulse_irq(); nb++;
    n = 0;
    while (!(BVALID && BREADY) && n < 100) begin
      @(negedge ACLK); n++;
    end
    @(negedge ACLK);
`ifdef PWM_SEQ_READBACK_EN
    chk("b_then_ar", ARVALID, 1);
`else
    chk("busy_fall", busy, 0);
`endif
    wait_done("stall_done"); expect_write("stall", 1);
    chk("stall_stable", stab_err, 0);
    chk("stall_one_b", b_count, nb);
    aw_wait = 0;

    // Overrun: two extra triggers while the response is stalled
    b_wait = 20;
    pulse_irq(); pulse_irq(); pulse_irq();
    nb += 2; wait_done("ovr_done");
    repeat (10) @(negedge ACLK);
    chk("ovr_count", b_count, nb);
    expect_write("ovr_a", 0); expect_write("ovr_b", 1);
    chk("ovr_set", overrun, 1);
    pulse_clr();
    chk("ovr_clr", overrun, 0);

    // Enable falls mid-transaction: pending dropped
    b_wait = 10;
    pulse_irq(); pulse_irq();
    enable = 1'b0;
    nb++; wait_done("en_done");
    repeat (5) @(negedge ACLK);
    chk("en_count", b_count, nb);
    expect_write("en", 1);
    enable = 1'b1; b_wait = 0;

    // Slave error response
    bresp_cfg = 2'b10;
    pulse_irq(); nb++; wait_done("slverr_done"); expect_write("slverr", 1);
    chk("slverr_err", err, 1);
    bresp_cfg = 2'b00;
    pulse_irq(); nb++; wait_done("after_err_done"); expect_write("after_err", 1);
    chk("err_sticky", err, 1);
    pulse_clr();
    chk("err_clr", err, 0);

    // Reset during the write response phase
    b_wait = 20;
    pulse_irq();
    n = 0;
    while (!BREADY && n < 100) begin
      @(negedge ACLK); n++;
    end
    ARESETN = 1'b0;
    #1;
    chk("arst_bready", BREADY, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valids", {AWVALID, WVALID}, 0);
    chk("arst_cur_idx", cur_idx, 0);
    @(negedge ACLK);
    ARESETN = 1'b1; b_wait = 0;
    @(negedge ACLK);
    pulse_start(); nb++; wait_done("arst_start_done"); expect_write("arst_start", 1);

`ifdef PWM_SEQ_READBACK_EN
    rd_xor = 32'h1;
    pulse_irq(); nb++; wait_done("rb_bad_done"); expect_write("rb_bad", 1);
    chk("rb_bad_err", err, 1);
    rd_xor = 32'h0;
    pulse_clr();
    for (int k = 0; k < 8; k++) begin
      pulse_irq(); nb++; wait_done("rb_ok_done"); expect_write("rb_ok", 0);
    end
    chk("rb_ok_err", err, 0);
    chk("rb_addr", rd_addr_err, 0);
`endif

    // Randomised tables, lengths and slave latencies
    for (int it = 0; it < 20; it++) begin
      for (int j = 0; j < 4; j++) tbl_write(int'($urandom_range(0, DEPTH - 1)), $urandom);
      set_len(int'($urandom_range(0, DEPTH)));
      aw_wait = int'($urandom_range(0, 3));
      w_wait  = int'($urandom_range(0, 3));
      b_wait  = int'($urandom_range(0, 3));
      pulse_start(); nb++; wait_done("rnd_start_done"); expect_write("rnd_start", 1);
      n = int'($urandom_range(1, 5));
      for (int k = 0; k < n; k++) begin
        pulse_irq(); nb++; wait_done("rnd_irq_done"); expect_write("rnd_irq", 1);
      end
    end
    chk("rnd_err", err, 0);
    chk("rnd_overrun", overrun, 0);
    chk("rnd_stable", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
